// File: rtl/fetch_addr_generate_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_addr_generate_stage : fetch PC generator (reset/run/halt/fault).   |
// | Optional: FETCH_ADDR_GEN_MISALIGN_CHECK_EN flags misaligned targets.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fetch_addr_generate_stage #(
   parameter logic [31:0] RESET_VECTOR = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        trap_valid,
   input  logic [31:0] trap_pc,
   input  logic        halt_req,
   input  logic        wake,
   output logic        valid,
   output logic [31:0] pc_vaddr,
   output logic        misaligned
);

   localparam logic [1:0] ST_RESET_WAIT = 2'd0;
   localparam logic [1:0] ST_RUN        = 2'd1;
   localparam logic [1:0] ST_HALTED     = 2'd2;
   localparam logic [1:0] ST_FAULTED    = 2'd3;

   localparam logic [3:0] ACT_HOLD      = 4'd0;
   localparam logic [3:0] ACT_BOOT      = 4'd1;
   localparam logic [3:0] ACT_LOAD_EV   = 4'd2;
   localparam logic [3:0] ACT_LOAD_PEND = 4'd3;
   localparam logic [3:0] ACT_KILL      = 4'd4;
   localparam logic [3:0] ACT_REFETCH   = 4'd5;
   localparam logic [3:0] ACT_SEQ       = 4'd6;
   localparam logic [3:0] ACT_HALT      = 4'd7;
   localparam logic [3:0] ACT_FAULT     = 4'd8;
   localparam logic [3:0] ACT_WAKE      = 4'd9;

   localparam logic [31:0] C_PC_STEP = 32'd4;

   logic [1:0]  state_q, state_d;
   logic        valid_q, valid_d;
   logic [31:0] pc_q, pc_d;
   logic        mis_q, mis_d;
   logic        pend_v_q, pend_v_d;
   logic [31:0] pend_pc_q, pend_pc_d;

   logic [3:0]  w_act;
   logic        w_ev;
   logic [31:0] w_ev_pc;
   logic [31:0] w_load_pc;
   logic [31:0] w_load_addr;
   logic        w_load_mis;
   logic        w_pc_mis;

   // Trap outranks redirect both for immediate loads and for the pending slot.
   assign w_ev      = trap_valid | redirect_valid;
   assign w_ev_pc   = trap_valid ? trap_pc : redirect_pc;
   assign w_load_pc = (w_act == ACT_LOAD_PEND) ? pend_pc_q : w_ev_pc;

`ifdef FETCH_ADDR_GEN_MISALIGN_CHECK_EN
   assign w_load_addr = w_load_pc;
   assign w_load_mis  = (w_load_pc[1:0] != 2'b00);
   assign w_pc_mis    = (pc_q[1:0] != 2'b00);
`else
   assign w_load_addr = w_load_pc & 32'hFFFF_FFFC;
   assign w_load_mis  = 1'b0;
   assign w_pc_mis    = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RESET_WAIT;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         pc_q      <= RESET_VECTOR;
         mis_q     <= 1'b0;
         pend_v_q  <= 1'b0;
         pend_pc_q <= 32'h0;
      end else begin
         valid_q   <= valid_d;
         pc_q      <= pc_d;
         mis_q     <= mis_d;
         pend_v_q  <= pend_v_d;
         pend_pc_q <= pend_pc_d;
      end
   end

   always_comb begin
      w_act = ACT_HOLD;
      if (w_ev && flush) begin
         w_act = ACT_LOAD_EV;
      end else if (state_q == ST_RESET_WAIT) begin
         w_act = ACT_BOOT;
      end else if (flush) begin
         w_act = (state_q == ST_RUN) ? ACT_KILL : ACT_HOLD;
      end else if (stall) begin
         w_act = ACT_HOLD;
      end else if (w_ev) begin
         w_act = ACT_LOAD_EV;
      end else if (pend_v_q) begin
         w_act = ACT_LOAD_PEND;
      end else begin
         case (state_q)
            ST_RUN: begin
               // A killed request (valid low) is reissued at the same pc.
               if (mis_q)          w_act = ACT_FAULT;
               else if (!valid_q)  w_act = ACT_REFETCH;
               else if (halt_req)  w_act = ACT_HALT;
               else                w_act = ACT_SEQ;
            end
            ST_HALTED: begin
               if (wake) w_act = ACT_WAKE;
            end
            default: w_act = ACT_HOLD;
         endcase
      end

      state_d = state_q;
      case (w_act)
         ACT_BOOT, ACT_LOAD_EV, ACT_LOAD_PEND, ACT_WAKE: state_d = ST_RUN;
         ACT_HALT:                                       state_d = ST_HALTED;
         ACT_FAULT:                                      state_d = ST_FAULTED;
         default:                                        state_d = state_q;
      endcase
   end

   always_comb begin
      valid_d   = valid_q;
      pc_d      = pc_q;
      mis_d     = mis_q;
      pend_v_d  = pend_v_q;
      pend_pc_d = pend_pc_q;

      case (w_act)
         ACT_BOOT: begin
            valid_d = 1'b1;
            pc_d    = RESET_VECTOR;
            mis_d   = 1'b0;
         end
         ACT_LOAD_EV, ACT_LOAD_PEND: begin
            valid_d = 1'b1;
            pc_d    = w_load_addr;
            mis_d   = w_load_mis;
         end
         ACT_KILL, ACT_FAULT: begin
            valid_d = 1'b0;
            mis_d   = 1'b0;
         end
         ACT_REFETCH, ACT_WAKE: begin
            valid_d = 1'b1;
            mis_d   = w_pc_mis;
         end
         ACT_SEQ: begin
            valid_d = 1'b1;
            pc_d    = pc_q + C_PC_STEP;
            mis_d   = 1'b0;
         end
         ACT_HALT: begin
            valid_d = 1'b0;
            pc_d    = pc_q + C_PC_STEP;
            mis_d   = 1'b0;
         end
         default: ;
      endcase

      // Any event not taken this cycle is parked; any target load retires it.
      if ((w_act == ACT_LOAD_EV) || (w_act == ACT_LOAD_PEND)) begin
         pend_v_d = 1'b0;
      end else if (w_ev) begin
         pend_v_d  = 1'b1;
         pend_pc_d = w_ev_pc;
      end
   end

   assign valid      = valid_q;
   assign pc_vaddr   = pc_q;
   assign misaligned = mis_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_addr_generate_stage.sv
`default_nettype none
// Bench for fetch_addr_generate_stage: directed stimulus feeds an expectation
// queue that a negedge monitor drains and compares against the outputs.
module tb_fetch_addr_generate_stage;

   localparam logic [31:0] RV = 32'h8000_0000;
   localparam logic [31:0] Z  = 32'h0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        trap_valid = 1'b0;
   logic [31:0] trap_pc = 32'h0;
   logic        halt_req = 1'b0;
   logic        wake = 1'b0;
   logic        valid;
   logic [31:0] pc_vaddr;
   logic        misaligned;

   typedef struct {
      string       tag;
      logic        v;
      logic [31:0] pc;
      logic        m;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fetch_addr_generate_stage #(.RESET_VECTOR(RV)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .trap_valid     (trap_valid),
      .trap_pc        (trap_pc),
      .halt_req       (halt_req),
      .wake           (wake),
      .valid          (valid),
      .pc_vaddr       (pc_vaddr),
      .misaligned     (misaligned)
   );

   always @(negedge clk) begin
      if (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         if (valid !== e.v || pc_vaddr !== e.pc || misaligned !== e.m) begin
            errors++;
            $display("FAIL %s: got valid=%0b pc=%08h mis=%0b, expected valid=%0b pc=%08h mis=%0b",
                     e.tag, valid, pc_vaddr, misaligned, e.v, e.pc, e.m);
         end
      end
   end

   task automatic expect_now(input string tag, input logic v, input logic [31:0] pc, input logic m);
      exp_t e;
      e.tag = tag;
      e.v   = v;
      e.pc  = pc;
      e.m   = m;
      q.push_back(e);
   endtask

   // Drive one cycle of inputs, then queue the outputs expected after the edge.
   task automatic cyc(input string tag, input logic st, input logic fl,
                      input logic rv, input logic [31:0] rpc,
                      input logic tv, input logic [31:0] tpc,
                      input logic hr, input logic wk,
                      input logic ev, input logic [31:0] epc, input logic em);
      stall          = st;
      flush          = fl;
      redirect_valid = rv;
      redirect_pc    = rpc;
      trap_valid     = tv;
      trap_pc        = tpc;
      halt_req       = hr;
      wake           = wk;
      @(posedge clk);
      #1;
      expect_now(tag, ev, epc, em);
   endtask

   task automatic clear_inputs();
      stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; trap_valid = 1'b0;
      halt_req = 1'b0; wake = 1'b0; redirect_pc = Z; trap_pc = Z;
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1 expect_now("reset_state", 1'b0, RV, 1'b0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      expect_now("boot_wait", 1'b0, RV, 1'b0);
      cyc("boot_first",   0,0, 0,Z, 0,Z, 0,0, 1, RV, 0);
      cyc("seq_04",       0,0, 0,Z, 0,Z, 0,0, 1, 32'h8000_0004, 0);
      cyc("seq_08",       0,0, 0,Z, 0,Z, 0,0, 1, 32'h8000_0008, 0);
      cyc("seq_0c",       0,0, 0,Z, 0,Z, 0,0, 1, 32'h8000_000C, 0);
      cyc("seq_10",       0,0, 0,Z, 0,Z, 0,0, 1, 32'h8000_0010, 0);
      // stalled redirect parks until the stall drops
      cyc("stall_rd_h1",  1,0, 1,32'h8000_0100, 0,Z, 0,0, 1, 32'h8000_0010, 0);
      cyc("stall_h2",     1,0, 0,Z, 0,Z, 0,0, 1, 32'h8000_0010, 0);
      cyc("pend_load",    0,0, 0,Z, 0,Z, 0,0, 1, 32'h8000_0100, 0);
      cyc("seq_104",      0,0, 0,Z, 0,Z, 0,0, 1, 32'h8000_0104, 0);
      cyc("trap_over_rd", 0,1, 1,32'h8000_0300, 1,32'h8000_0200, 0,0, 1, 32'h8000_0200, 0);
      cyc("seq_204",      0,0, 0,Z, 0,Z, 0,0, 1, 32'h8000_0204, 0);
      cyc("pend_rd1",     1,0, 1,32'h8000_0500, 0,Z, 0,0, 1, 32'h8000_0204, 0);
      cyc("pend_rd2",     1,0, 1,32'h8000_0540, 0,Z, 0,0, 1, 32'h8000_0204, 0);
      cyc("pend_later",   0,0, 0,Z, 0,Z, 0,0, 1, 32'h8000_0540, 0);
      cyc("pend_rd3",     1,0, 1,32'h8000_0580, 0,Z, 0,0, 1, 32'h8000_0540, 0);
      cyc("pend_trap",    1,0, 0,Z, 1,32'h8000_0600, 0,0, 1, 32'h8000_0540, 0);
      cyc("pend_trapwin", 0,0, 0,Z, 0,Z, 0,0, 1, 32'h8000_0600, 0);
      cyc("seq_604",      0,0, 0,Z, 0,Z, 0,0, 1, 32'h8000_0604, 0);
      cyc("flush_kill",   0,1, 0,Z, 0,Z, 0,0, 0, 32'h8000_0604, 0);
      cyc("flush_stall",  1,0, 0,Z, 0,Z, 0,0, 0, 32'h8000_0604, 0);
      cyc("refetch",      0,0, 0,Z, 0,Z, 0,0, 1, 32'h8000_0604, 0);
      cyc("seq_608",      0,0, 0,Z, 0,Z, 0,0, 1, 32'h8000_0608, 0);
      cyc("to_020",       0,1, 1,32'h8000_0020, 0,Z, 0,0, 1, 32'h8000_0020, 0);
      cyc("halt",         0,0, 0,Z, 0,Z, 1,0, 0, 32'h8000_0024, 0);
      cyc("halted_hold",  0,0, 0,Z, 0,Z, 0,0, 0, 32'h8000_0024, 0);
      cyc("halted_hr",    0,0, 0,Z, 0,Z, 1,0, 0, 32'h8000_0024, 0);
      cyc("wake",         0,0, 0,Z, 0,Z, 0,1, 1, 32'h8000_0024, 0);
      cyc("to_fff8",      0,1, 1,32'hFFFF_FFF8, 0,Z, 0,0, 1, 32'hFFFF_FFF8, 0);
      cyc("seq_fffc",     0,0, 0,Z, 0,Z, 0,0, 1, 32'hFFFF_FFFC, 0);
      cyc("wrap_0",       0,0, 0,Z, 0,Z, 0,0, 1, 32'h0000_0000, 0);
      cyc("seq_4",        0,0, 0,Z, 0,Z, 0,0, 1, 32'h0000_0004, 0);
      cyc("halt2",        0,0, 0,Z, 0,Z, 1,0, 0, 32'h0000_0008, 0);
      cyc("trap_vs_wake", 0,0, 0,Z, 1,32'h8000_0700, 0,1, 1, 32'h8000_0700, 0);
      cyc("flush_rd_stl", 1,1, 1,32'h8000_0800, 0,Z, 0,0, 1, 32'h8000_0800, 0);
`ifdef FETCH_ADDR_GEN_MISALIGN_CHECK_EN
      cyc("mis_load",     0,1, 1,32'h8000_0102, 0,Z, 0,0, 1, 32'h8000_0102, 1);
      cyc("mis_fault",    0,0, 0,Z, 0,Z, 0,0, 0, 32'h8000_0102, 0);
      cyc("fault_hold",   0,0, 0,Z, 0,Z, 0,0, 0, 32'h8000_0102, 0);
`else
      cyc("mis_load",     0,1, 1,32'h8000_0102, 0,Z, 0,0, 1, 32'h8000_0100, 0);
      cyc("mis_seq1",     0,0, 0,Z, 0,Z, 0,0, 1, 32'h8000_0104, 0);
      cyc("mis_seq2",     0,0, 0,Z, 0,Z, 0,0, 1, 32'h8000_0108, 0);
`endif
      cyc("rd_400",       0,0, 1,32'h8000_0400, 0,Z, 0,0, 1, 32'h8000_0400, 0);
      cyc("halt3",        0,0, 0,Z, 0,Z, 1,0, 0, 32'h8000_0404, 0);
      cyc("halt3_pend",   1,0, 1,32'h8000_0900, 0,Z, 0,0, 0, 32'h8000_0404, 0);
      @(negedge clk);
      #1;
      clear_inputs();
      rst_n = 1'b0;
      #1 expect_now("mid_reset", 1'b0, RV, 1'b0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      expect_now("reboot_wait", 1'b0, RV, 1'b0);
      cyc("reboot_first", 0,0, 0,Z, 0,Z, 0,0, 1, RV, 0);
      cyc("reboot_seq",   0,0, 0,Z, 0,Z, 0,0, 1, 32'h8000_0004, 0);
      @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
